// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of one synchronous-read memory
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int DATA_PRIO  = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

    owner_t     owner, owner_nxt;
    logic       last_gnt_d, last_gnt_d_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       fetch_wins;

    always_comb begin
        fetch_wins     = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        owner_nxt      = OWN_NONE;
        last_gnt_d_nxt = last_gnt_d;
        starve_nxt     = 4'd0;

        if (if_req) begin
            if (!d_req)
                fetch_wins = 1'b1;
            else if (DATA_PRIO != 0)
                fetch_wins = (starve_cnt == STARVE_MAX);
            else
                fetch_wins = last_gnt_d;
        end

        // Reset blocks every grant, so nothing reaches memory while it is held.
        if_gnt = !reset && fetch_wins;
        d_gnt  = !reset && d_req && !fetch_wins;

        if (if_gnt) begin
            mem_addr       = if_addr;
            owner_nxt      = OWN_IF;
            last_gnt_d_nxt = 1'b0;
        end else if (d_gnt) begin
            mem_we         = d_we;
            mem_addr       = d_addr;
            mem_wdata      = d_wdata;
            owner_nxt      = d_we ? OWN_NONE : OWN_D;
            last_gnt_d_nxt = 1'b1;
        end

        if ((DATA_PRIO != 0) && if_req && !if_gnt)
            starve_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWN_NONE;
            last_gnt_d <= 1'b1;
            starve_cnt <= 4'd0;
        end else begin
            owner      <= owner_nxt;
            last_gnt_d <= last_gnt_d_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Responses follow the registered owner; unowned cycles return zero data.
    assign if_rvalid = (owner == OWN_IF);
    assign d_rvalid  = (owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    assign busy      = (owner != OWN_NONE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter in both arbitration modes
module tb_mem_port_arbiter;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        if_gnt;
        logic        d_gnt;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        if_rvalid;
        logic        d_rvalid;
        logic        busy;
    } exp_t;

    logic clk = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   done [2];

    always #5 clk = ~clk;

    function automatic void chk(input string n, input int id, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL env%0d %s: got %h expected %h", id, n, a, x);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : env
        localparam int P  = (g == 0) ? 1 : 0;
        localparam int MS = 4;

        logic        rst, mem_clr;
        logic        if_req, if_gnt, if_rvalid;
        logic [31:0] if_addr, if_rdata;
        logic        d_req, d_we, d_gnt, d_rvalid;
        logic [31:0] d_addr, d_wdata, d_rdata;
        logic        mem_we, busy;
        logic [31:0] mem_addr, mem_wdata, mem_rdata;
        logic [31:0] mem [0:255];

        mem_port_arbiter #(.AW(32), .DW(32), .DATA_PRIO(P), .MAX_STARVE(MS)) dut (
            .clk(clk), .reset(rst),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
            .if_rvalid(if_rvalid), .if_rdata(if_rdata),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
            .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
            .mem_rdata(mem_rdata), .busy(busy)
        );

        always @(posedge clk) begin
            if (mem_clr) begin
                for (int i = 0; i < 256; i++) mem[i] <= '0;
            end else begin
                if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
                mem_rdata <= mem[mem_addr[7:0]];
            end
        end

        // Reference model: pending read owner (0 none, 1 fetch, 2 data), last winner, starvation count.
        int          own = 0;
        bit          last_d = 1'b1;
        int          starve = 0;
        bit          pgi, pgd, pwe, pir;
        bit          rst_edge = 1'b1;
        logic [31:0] prd;
        bit          ia, da;
        req_t        ic, dc;
        req_t        if_q[$];
        req_t        d_q[$];
        logic [31:0] ifd_q[$];
        logic [31:0] dd_q[$];
        exp_t        exp_q[$];
        logic [31:0] ref_mem [0:255];

        task automatic cycle(input bit early, input bit late, input bit rnd);
            exp_t e;
            req_t r;
            bit   gi, gd;
            @(posedge clk);
            if (rst_edge) begin
                own = 0; last_d = 1'b1; starve = 0;
            end else begin
                own = pgi ? 1 : ((pgd && !pwe) ? 2 : 0);
                if (pgi) last_d = 1'b0;
                else if (pgd) last_d = 1'b1;
                if (P != 0) starve = (pir && !pgi) ? ((starve < MS) ? starve + 1 : MS) : 0;
                if (pgi) ia = 1'b0;
                if (pgd) da = 1'b0;
            end
            if (own == 1) ifd_q.push_back(prd);
            else if (own == 2) dd_q.push_back(prd);
            #1;
            if (rnd) begin
                if (!ia && if_q.size() == 0 && $urandom_range(0, 9) < 6) begin
                    r.we = 1'b0; r.addr = $urandom(); r.wdata = '0;
                    if_q.push_back(r);
                end
                if (!da && d_q.size() == 0 && $urandom_range(0, 9) < 6) begin
                    r.we = 1'($urandom_range(0, 1)); r.addr = $urandom(); r.wdata = $urandom();
                    d_q.push_back(r);
                end
            end
            if (!ia && if_q.size() > 0) begin ic = if_q.pop_front(); ia = 1'b1; end
            if (!da && d_q.size() > 0) begin dc = d_q.pop_front(); da = 1'b1; end
            rst     = early;
            if_req  = ia;
            if_addr = ia ? ic.addr : $urandom();
            d_req   = da;
            d_we    = da ? dc.we : 1'($urandom_range(0, 1));
            d_addr  = da ? dc.addr : $urandom();
            d_wdata = da ? dc.wdata : $urandom();
            gi = 1'b0; gd = 1'b0;
            if (!early) begin
                if (ia && !da) gi = 1'b1;
                else if (da && !ia) gd = 1'b1;
                else if (ia && da) begin
                    gi = (P != 0) ? (starve == MS) : last_d;
                    gd = !gi;
                end
            end
            e.if_gnt    = gi;
            e.d_gnt     = gd;
            e.mem_we    = gd && dc.we;
            e.mem_addr  = gi ? ic.addr : (gd ? dc.addr : 32'h0);
            e.mem_wdata = gd ? dc.wdata : 32'h0;
            e.if_rvalid = (own == 1);
            e.d_rvalid  = (own == 2);
            e.busy      = (own != 0);
            exp_q.push_back(e);
            pgi = gi; pgd = gd; pwe = dc.we; pir = ia;
            prd = gi ? ref_mem[ic.addr[7:0]] : ref_mem[dc.addr[7:0]];
            @(negedge clk);
            #1;
            if (late) rst = 1'b1;
            rst_edge = rst;
            if (rst_edge) begin
                pgi = 1'b0; pgd = 1'b0;
            end else if (gd && dc.we) begin
                ref_mem[dc.addr[7:0]] = dc.wdata;
            end
        endtask

        task automatic drain();
            for (int k = 0; k < 60 && (ia || da || if_q.size() > 0 || d_q.size() > 0); k++)
                cycle(1'b0, 1'b0, 1'b0);
        endtask

        always @(negedge clk) begin
            exp_t e;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("if_gnt", g, 32'(if_gnt), 32'(e.if_gnt));
                chk("d_gnt", g, 32'(d_gnt), 32'(e.d_gnt));
                chk("mem_we", g, 32'(mem_we), 32'(e.mem_we));
                chk("mem_addr", g, mem_addr, e.mem_addr);
                if (!e.if_gnt) chk("mem_wdata", g, mem_wdata, e.mem_wdata);
                chk("if_rvalid", g, 32'(if_rvalid), 32'(e.if_rvalid));
                chk("d_rvalid", g, 32'(d_rvalid), 32'(e.d_rvalid));
                chk("busy", g, 32'(busy), 32'(e.busy));
                if (if_rvalid) begin
                    if (ifd_q.size() > 0) chk("if_rdata", g, if_rdata, ifd_q.pop_front());
                    else begin total++; bad++; $display("FAIL env%0d if_rsp_extra: got %h expected none", g, if_rdata); end
                end else chk("if_rdata_idle", g, if_rdata, 32'h0);
                if (d_rvalid) begin
                    if (dd_q.size() > 0) chk("d_rdata", g, d_rdata, dd_q.pop_front());
                    else begin total++; bad++; $display("FAIL env%0d d_rsp_extra: got %h expected none", g, d_rdata); end
                end else chk("d_rdata_idle", g, d_rdata, 32'h0);
            end
        end

        initial begin
            req_t r;
            rst = 1'b1; mem_clr = 1'b1;
            if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
            if_addr = '0; d_addr = '0; d_wdata = '0;
            ia = 1'b0; da = 1'b0; ic = '0; dc = '0;
            for (int i = 0; i < 256; i++) ref_mem[i] = '0;
            repeat (3) cycle(1'b1, 1'b0, 1'b0);
            mem_clr = 1'b0;
            // fetch of a stored instruction word, then store followed by load
            r = '{we: 1'b1, addr: 32'h10, wdata: 32'h00500093}; d_q.push_back(r); drain();
            r = '{we: 1'b0, addr: 32'h10, wdata: 32'h0};        if_q.push_back(r); drain();
            r = '{we: 1'b1, addr: 32'h40, wdata: 32'hDEADBEEF}; d_q.push_back(r);
            r = '{we: 1'b0, addr: 32'h40, wdata: 32'h0};        d_q.push_back(r); drain();
            repeat (3) cycle(1'b0, 1'b0, 1'b0);
            // continuous contention straight out of reset
            cycle(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 8; i++) begin
                r = '{we: 1'b0, addr: 32'h100 + 32'(4 * i), wdata: 32'h0}; if_q.push_back(r);
                r = '{we: 1'(i % 2), addr: 32'h200 + 32'(4 * i), wdata: $urandom()}; d_q.push_back(r);
            end
            drain();
            // reset arriving at the edge that ends a fetch grant
            r = '{we: 1'b0, addr: 32'h40, wdata: 32'h0}; if_q.push_back(r);
            cycle(1'b0, 1'b1, 1'b0);
            cycle(1'b1, 1'b0, 1'b0);
            drain();
            for (int i = 0; i < 400; i++)
                cycle($urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0, 1'b1);
            drain();
            repeat (3) cycle(1'b0, 1'b0, 1'b0);
            @(posedge clk);
            @(negedge clk);
            chk("if_rsp_left", g, 32'(ifd_q.size()), 32'h0);
            chk("d_rsp_left", g, 32'(dd_q.size()), 32'h0);
            done[g] = 1'b1;
        end
    end

    initial begin
        fork
            wait (done[0] && done[1]);
            #200000;
        join_any
        disable fork;
        if (!(done[0] && done[1])) begin
            total++; bad++;
            $display("FAIL timeout: got done=%0b%0b expected 11", done[1], done[0]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
